// File: rtl/multi_lock_manager_if.sv
// Stream interface for the lock manager: a request stream in towards the
// manager and a response stream out towards the accelerators.
interface multi_lock_manager_if #(
  parameter int ACC_BITS = 4
);
  logic                inStream_TVALID;
  logic                inStream_TREADY;
  logic [63:0]         inStream_TDATA;
  logic [ACC_BITS-1:0] inStream_TID;

  logic                outStream_TVALID;
  logic                outStream_TREADY;
  logic [63:0]         outStream_TDATA;
  logic [ACC_BITS-1:0] outStream_TDEST;
  logic                outStream_TLAST;

  // Accelerator side: issues requests, consumes responses.
  modport master (
    output inStream_TVALID, inStream_TDATA, inStream_TID,
    input  inStream_TREADY,
    input  outStream_TVALID, outStream_TDATA, outStream_TDEST, outStream_TLAST,
    output outStream_TREADY
  );

  // Lock manager side.
  modport slave (
    input  inStream_TVALID, inStream_TDATA, inStream_TID,
    output inStream_TREADY,
    output outStream_TVALID, outStream_TDATA, outStream_TDEST, outStream_TLAST,
    input  outStream_TREADY
  );
endinterface

// File: rtl/multi_lock_manager.sv
// Multi-lock manager: serialises LOCK / UNLOCK / TRYLOCK requests from a set
// of accelerators over a set of independent locks. Each lock keeps a busy
// bit, an owner and a waiter mask; UNLOCK hands ownership round-robin to the
// next waiter above the old owner.
module multi_lock_manager #(
  parameter int MAX_ACCS  = 16,
  parameter int ACC_BITS  = $clog2(MAX_ACCS),
  parameter int NUM_LOCKS = 8,
  parameter int LOCK_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  multi_lock_manager_if.slave  bus,
  output logic [NUM_LOCKS-1:0] lock_busy,
  output logic                 err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] OP_LOCK     = 8'h04;
  localparam logic [7:0] OP_UNLOCK   = 8'h06;
  localparam logic [7:0] OP_TRYLOCK  = 8'h08;
  localparam logic [7:0] RESP_GRANT  = 8'h05;
  localparam logic [7:0] RESP_FAIL   = 8'h07;

  localparam logic [MAX_ACCS-1:0] ONE_ACC = {{(MAX_ACCS-1){1'b0}}, 1'b1};

  // First set bit of mask searching upward from cur+1, wrapping modulo MAX_ACCS.
  function automatic logic [ACC_BITS-1:0] next_owner(
    input logic [ACC_BITS-1:0] cur,
    input logic [MAX_ACCS-1:0] mask
  );
    logic [ACC_BITS-1:0] res;
    logic [ACC_BITS-1:0] idx;
    logic                found;
    int                  cand;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= MAX_ACCS; k++) begin
      cand = (int'(cur) + k) % MAX_ACCS;
      idx  = cand[ACC_BITS-1:0];
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic                tready_r;
  logic [15:0]         req_data_r;
  logic [ACC_BITS-1:0] req_tid_r;

  logic                out_valid_r;
  logic [63:0]         out_data_r;
  logic [ACC_BITS-1:0] out_dest_r;
  logic                out_last_r;

  logic [NUM_LOCKS-1:0] busy_r;
  logic [ACC_BITS-1:0]  owner_r   [NUM_LOCKS];
  logic [MAX_ACCS-1:0]  waiters_r [NUM_LOCKS];
  logic                 err_r;

  logic                 accept_s;
  logic                 resp_done_s;
  logic [7:0]           op_s;
  logic [7:0]           lid_s;
  logic [LOCK_BITS-1:0] lidx_s;
  logic                 id_ok_s;
  logic                 cur_busy_s;
  logic [ACC_BITS-1:0]  cur_owner_s;
  logic [MAX_ACCS-1:0]  cur_wait_s;
  logic [ACC_BITS-1:0]  new_owner_s;

  logic                 nb_busy_s;
  logic [ACC_BITS-1:0]  nb_owner_s;
  logic [MAX_ACCS-1:0]  nb_wait_s;
  logic                 resp_due_s;
  logic [7:0]           resp_code_s;
  logic [ACC_BITS-1:0]  resp_dest_s;
  logic                 err_set_s;

  // Upper request bits carry no meaning for this block.
  logic unused_hi_s;
  assign unused_hi_s = ^bus.inStream_TDATA[63:16];

  assign accept_s    = (state_r == ST_IDLE) && tready_r && bus.inStream_TVALID;
  assign resp_done_s = (state_r == ST_RESP) && out_valid_r && bus.outStream_TREADY;

  assign op_s        = req_data_r[7:0];
  assign lid_s       = req_data_r[15:8];
  assign lidx_s      = lid_s[LOCK_BITS-1:0];
  assign id_ok_s     = ({1'b0, lid_s} < 9'(NUM_LOCKS));
  assign cur_busy_s  = busy_r[lidx_s];
  assign cur_owner_s = owner_r[lidx_s];
  assign cur_wait_s  = waiters_r[lidx_s];
  assign new_owner_s = next_owner(cur_owner_s, cur_wait_s);

  // Decide the new state of the addressed lock and whether a response is due.
  always_comb begin
    nb_busy_s   = cur_busy_s;
    nb_owner_s  = cur_owner_s;
    nb_wait_s   = cur_wait_s;
    resp_due_s  = 1'b0;
    resp_code_s = RESP_GRANT;
    resp_dest_s = req_tid_r;
    err_set_s   = 1'b0;
    if (!id_ok_s) begin
      err_set_s = 1'b1;
    end else begin
      case (op_s)
        OP_LOCK, OP_TRYLOCK: begin
          if (!cur_busy_s) begin
            nb_busy_s  = 1'b1;
            nb_owner_s = req_tid_r;
            resp_due_s = 1'b1;
          end else if (cur_owner_s == req_tid_r) begin
            err_set_s = 1'b1;
          end else if (op_s == OP_LOCK) begin
            nb_wait_s = cur_wait_s | (ONE_ACC << req_tid_r);
          end else begin
            resp_due_s  = 1'b1;
            resp_code_s = RESP_FAIL;
          end
        end
        OP_UNLOCK: begin
          if (!cur_busy_s || (cur_owner_s != req_tid_r)) begin
            err_set_s = 1'b1;
          end else if (cur_wait_s == {MAX_ACCS{1'b0}}) begin
            nb_busy_s = 1'b0;
          end else begin
            nb_owner_s  = new_owner_s;
            nb_wait_s   = cur_wait_s & ~(ONE_ACC << new_owner_s);
            resp_due_s  = 1'b1;
            resp_dest_s = new_owner_s;
          end
        end
        default: begin
          err_set_s = 1'b1;
        end
      endcase
    end
  end

  // Request/response sequencing: IDLE accepts, EXEC updates, RESP waits for sink.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_EXEC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (resp_due_s) state_nxt_s = ST_RESP;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RESP: begin
        if (resp_done_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, registered TREADY and latched request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_IDLE;
      tready_r   <= 1'b0;
      req_data_r <= 16'h0000;
      req_tid_r  <= {ACC_BITS{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      tready_r <= (state_nxt_s == ST_IDLE);
      if (accept_s) begin
        req_data_r <= bus.inStream_TDATA[15:0];
        req_tid_r  <= bus.inStream_TID;
      end else begin
        req_data_r <= req_data_r;
        req_tid_r  <= req_tid_r;
      end
    end
  end

  // Response register: loaded at the end of EXEC, held until consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 64'h0;
      out_dest_r  <= {ACC_BITS{1'b0}};
      out_last_r  <= 1'b0;
    end else if ((state_r == ST_EXEC) && resp_due_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= {48'h0, lid_s, resp_code_s};
      out_dest_r  <= resp_dest_s;
      out_last_r  <= 1'b1;
    end else if (resp_done_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

  // Lock table update at the end of EXEC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_r <= {NUM_LOCKS{1'b0}};
      for (int i = 0; i < NUM_LOCKS; i++) begin
        owner_r[i]   <= {ACC_BITS{1'b0}};
        waiters_r[i] <= {MAX_ACCS{1'b0}};
      end
    end else if ((state_r == ST_EXEC) && id_ok_s) begin
      busy_r[lidx_s]    <= nb_busy_s;
      owner_r[lidx_s]   <= nb_owner_s;
      waiters_r[lidx_s] <= nb_wait_s;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_EXEC) && err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.inStream_TREADY  = tready_r;
  assign bus.outStream_TVALID = out_valid_r;
  assign bus.outStream_TDATA  = out_data_r;
  assign bus.outStream_TDEST  = out_dest_r;
  assign bus.outStream_TLAST  = out_last_r;
  assign lock_busy            = busy_r;
  assign err                  = err_r;

endmodule

// File: tb/tb_multi_lock_manager.sv
// Scoreboard bench for multi_lock_manager: directed requests push expected
// responses; a negedge monitor pops and compares every consumed response.
module tb_multi_lock_manager;

  localparam int ACC_BITS  = 4;
  localparam int NUM_LOCKS = 8;

  typedef struct packed {
    logic [ACC_BITS-1:0] dest;
    logic [63:0]         data;
  } resp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NUM_LOCKS-1:0] lock_busy;
  logic err;

  int checks = 0;
  int failures = 0;
  resp_t sb[$];

  multi_lock_manager_if #(.ACC_BITS(ACC_BITS)) bus ();

  multi_lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(NUM_LOCKS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .lock_busy (lock_busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] resp_word(input logic [7:0] code, input logic [7:0] lid);
    return {48'h0, lid, code};
  endfunction

  task automatic expect_resp(input logic [7:0] code, input logic [7:0] lid, input logic [3:0] dest);
    resp_t r;
    r.data = resp_word(code, lid);
    r.dest = dest;
    sb.push_back(r);
  endtask

  // Drive one request; returns one cycle after the handshake edge (EXEC cycle).
  task automatic send(input logic [7:0] op, input logic [7:0] lid, input logic [3:0] tid,
                      output int waits);
    int n;
    n = 0;
    bus.inStream_TVALID = 1'b1;
    bus.inStream_TDATA  = {48'hDEAD_BEEF_0000, lid, op};
    bus.inStream_TID    = tid;
    while (bus.inStream_TREADY !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout actual=no_tready required=tready_within_40");
    end
    @(posedge clk); #1;
    bus.inStream_TVALID = 1'b0;
    bus.inStream_TDATA  = 64'h0;
    waits = n;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_tready"}, {63'h0, bus.inStream_TREADY}, 64'h0);
    check({tag, "_out_tvalid"}, {63'h0, bus.outStream_TVALID}, 64'h0);
    check({tag, "_out_tdata"}, bus.outStream_TDATA, 64'h0);
    check({tag, "_out_tdest"}, {60'h0, bus.outStream_TDEST}, 64'h0);
    check({tag, "_out_tlast"}, {63'h0, bus.outStream_TLAST}, 64'h0);
    check({tag, "_lock_busy"}, {56'h0, lock_busy}, 64'h0);
    check({tag, "_err"}, {63'h0, err}, 64'h0);
  endtask

  // Full reset pulse starting from posedge+1; ends at posedge+1 with TREADY up.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(posedge clk); #3;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_release_tready", {63'h0, bus.inStream_TREADY}, 64'h1);
  endtask

  // Response monitor: compares each consumed response against the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (rstn && bus.outStream_TVALID && bus.outStream_TREADY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h/%0d expected=none",
                 bus.outStream_TDATA, bus.outStream_TDEST);
      end else begin
        e = sb.pop_front();
        check("resp_data", bus.outStream_TDATA, e.data);
        check("resp_dest", {60'h0, bus.outStream_TDEST}, {60'h0, e.dest});
        check("resp_last", {63'h0, bus.outStream_TLAST}, 64'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [63:0] held;
    bus.inStream_TVALID  = 1'b0;
    bus.inStream_TDATA   = 64'h0;
    bus.inStream_TID     = 4'h0;
    bus.outStream_TREADY = 1'b1;

    // Reset state while rstn is low, then TREADY in the first cycle after release.
    @(posedge clk); #1;
    do_reset();

    // Basic grant: LOCK 3 from TID 5, TVALID exactly two cycles after handshake.
    expect_resp(8'h05, 8'd3, 4'd5);
    send(8'h04, 8'd3, 4'd5, w);
    check("grant_lat_cycle1", {63'h0, bus.outStream_TVALID}, 64'h0);
    @(posedge clk); #1;
    check("grant_lat_cycle2", {63'h0, bus.outStream_TVALID}, 64'h1);
    check("grant_busy3", {63'h0, lock_busy[3]}, 64'h1);

    // Waiter queue on lock 2: owner 1, waiters 7,3,9 -> grants 3,7,9.
    expect_resp(8'h05, 8'd2, 4'd1);
    send(8'h04, 8'd2, 4'd1, w);
    send(8'h04, 8'd2, 4'd7, w);
    send(8'h04, 8'd2, 4'd3, w);
    send(8'h04, 8'd2, 4'd9, w);
    expect_resp(8'h05, 8'd2, 4'd3);
    send(8'h06, 8'd2, 4'd1, w);
    expect_resp(8'h05, 8'd2, 4'd7);
    send(8'h06, 8'd2, 4'd3, w);
    expect_resp(8'h05, 8'd2, 4'd9);
    send(8'h06, 8'd2, 4'd7, w);
    send(8'h06, 8'd2, 4'd9, w);
    cycles(1);
    check("queue_busy2_free", {63'h0, lock_busy[2]}, 64'h1 ^ 64'h1);
    check("queue_busy_vec", {56'h0, lock_busy}, 64'h08);
    check("queue_err", {63'h0, err}, 64'h0);

    // Round-robin wrap on lock 1: owner 12, waiters 2 and 14 -> 14 then 2.
    expect_resp(8'h05, 8'd1, 4'd12);
    send(8'h04, 8'd1, 4'd12, w);
    send(8'h04, 8'd1, 4'd2, w);
    send(8'h04, 8'd1, 4'd14, w);
    expect_resp(8'h05, 8'd1, 4'd14);
    send(8'h06, 8'd1, 4'd12, w);
    expect_resp(8'h05, 8'd1, 4'd2);
    send(8'h06, 8'd1, 4'd14, w);
    send(8'h06, 8'd1, 4'd2, w);
    cycles(1);
    check("wrap_busy1_free", {56'h0, lock_busy}, 64'h08);

    // Backpressure: GRANT held 10 cycles with sink not ready.
    bus.outStream_TREADY = 1'b0;
    expect_resp(8'h05, 8'd5, 4'd2);
    send(8'h04, 8'd5, 4'd2, w);
    @(posedge clk); #1;
    held = bus.outStream_TDATA;
    check("bp_first_data", held, 64'h0505);
    for (int i = 0; i < 10; i++) begin
      check("bp_tvalid", {63'h0, bus.outStream_TVALID}, 64'h1);
      check("bp_tdata", bus.outStream_TDATA, 64'h0505);
      check("bp_in_tready", {63'h0, bus.inStream_TREADY}, 64'h0);
      @(posedge clk); #1;
    end
    bus.outStream_TREADY = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", {63'h0, bus.inStream_TREADY}, 64'h1);
    send(8'h06, 8'd5, 4'd2, w);
    check("bp_accept_wait", w, 0);
    cycles(1);
    check("bp_busy5_free", {63'h0, lock_busy[5]}, 64'h0);

    // TRYLOCK fail on lock 0 held by 4, then UNLOCK by non-owner 6.
    expect_resp(8'h05, 8'd0, 4'd4);
    send(8'h04, 8'd0, 4'd4, w);
    expect_resp(8'h07, 8'd0, 4'd6);
    send(8'h08, 8'd0, 4'd6, w);
    cycles(2);
    check("try_no_err", {63'h0, err}, 64'h0);
    send(8'h06, 8'd0, 4'd6, w);
    cycles(1);
    check("nonowner_unlock_err", {63'h0, err}, 64'h1);
    check("nonowner_busy0", {63'h0, lock_busy[0]}, 64'h1);
    send(8'h06, 8'd0, 4'd4, w);
    cycles(2);
    check("try_waiters_empty", {63'h0, lock_busy[0]}, 64'h0);

    // TRYLOCK on a free lock grants; relock by the owner is an error.
    do_reset();
    expect_resp(8'h05, 8'd6, 4'd3);
    send(8'h08, 8'd6, 4'd3, w);
    send(8'h04, 8'd6, 4'd3, w);
    cycles(1);
    check("relock_err", {63'h0, err}, 64'h1);
    check("relock_busy", {56'h0, lock_busy}, 64'h40);

    // Out-of-range lock id.
    do_reset();
    send(8'h04, 8'hFF, 4'd1, w);
    cycles(1);
    check("badid_err", {63'h0, err}, 64'h1);
    check("badid_busy", {56'h0, lock_busy}, 64'h0);

    // Unknown opcode.
    do_reset();
    send(8'h05, 8'd1, 4'd1, w);
    cycles(1);
    check("badop_err", {63'h0, err}, 64'h1);
    check("badop_busy", {56'h0, lock_busy}, 64'h0);

    // Reset in the middle of RESP drops the response.
    do_reset();
    bus.outStream_TREADY = 1'b0;
    send(8'h04, 8'd7, 4'd1, w);
    @(posedge clk); #1;
    check("midresp_tvalid", {63'h0, bus.outStream_TVALID}, 64'h1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midresp");
    @(posedge clk); #3;
    rstn = 1'b1;
    bus.outStream_TREADY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("midresp_no_tvalid", {63'h0, bus.outStream_TVALID}, 64'h0);
    end
    check("midresp_busy", {56'h0, lock_busy}, 64'h0);

    cycles(3);
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
